// File: rtl/oam_dma_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_controller_if
// Brief    : CPU-side, memory-side and PPU-register-side signals of the sprite
//            DMA sequencer, bundled with controller/environment views.
// Revision : 1.0 - initial release
// ============================================================================
interface oam_dma_controller_if;
    logic        cpu_ce;
    logic        rdy_in;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        rdy_out;
    logic        bus_grant;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        ppu_reg_cs;
    logic [2:0]  ppu_reg_addr;
    logic [7:0]  ppu_wdata;
    logic        ppu_we;
    logic        dma_busy;

    modport master (
        input  cpu_ce, rdy_in, cpu_addr, cpu_wdata, cpu_we, mem_rdata,
        output rdy_out, bus_grant, mem_addr, mem_rd, ppu_reg_cs,
               ppu_reg_addr, ppu_wdata, ppu_we, dma_busy
    );

    modport slave (
        output cpu_ce, rdy_in, cpu_addr, cpu_wdata, cpu_we, mem_rdata,
        input  rdy_out, bus_grant, mem_addr, mem_rd, ppu_reg_cs,
               ppu_reg_addr, ppu_wdata, ppu_we, dma_busy
    );
endinterface
`default_nettype wire

// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_controller
// Brief    : $4014 sprite DMA; stalls the CPU and copies one 256-byte page
//            into PPU OAM via the OAM data register, one read/write pair per byte.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [2:0]  OAM_DATA_REG = 3'd4,
    parameter int          XFER_LEN     = 256
) (
    input  wire logic           CLOCK_50,
    input  wire logic           reset,
    oam_dma_controller_if.master bus
);

    localparam logic [7:0] c_last_idx = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic        r_parity;
    logic        r_stall;
    logic        r_busy;
    logic        r_bus_grant;
    logic        r_mem_rd;
    logic [15:0] r_mem_addr;
    logic        r_ppu_reg_cs;
    logic [2:0]  r_ppu_reg_addr;
    logic [7:0]  r_ppu_wdata;
    logic        r_ppu_we;

    logic        w_step;
    logic        w_trigger;
    logic [7:0]  w_idx_inc;

    assign w_step    = bus.cpu_ce & bus.rdy_in;
    assign w_trigger = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);
    assign w_idx_inc = r_idx + 8'd1;

    // Outputs are registered alongside the state they decode, so each one
    // holds steady for the whole CPU cycle and freezes with the FSM.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_page         <= 8'd0;
            r_idx          <= 8'd0;
            r_parity       <= 1'b0;
            r_stall        <= 1'b0;
            r_busy         <= 1'b0;
            r_bus_grant    <= 1'b0;
            r_mem_rd       <= 1'b0;
            r_mem_addr     <= 16'd0;
            r_ppu_reg_cs   <= 1'b0;
            r_ppu_reg_addr <= 3'd0;
            r_ppu_wdata    <= 8'd0;
            r_ppu_we       <= 1'b0;
        end else begin
            if (bus.cpu_ce) begin
                r_parity <= ~r_parity;
            end
            if (w_step) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_trigger) begin
                            r_state <= S_HALT;
                            r_page  <= bus.cpu_wdata;
                            r_idx   <= 8'd0;
                            r_busy  <= 1'b1;
                            r_stall <= 1'b1;
                        end
                    end
                    S_HALT: begin
                        // The 6502 ignores RDY on write cycles, so wait for a read.
                        if (!bus.cpu_we) begin
                            if (r_parity) begin
                                r_state <= S_ALIGN;
                            end else begin
                                r_state     <= S_READ;
                                r_bus_grant <= 1'b1;
                                r_mem_rd    <= 1'b1;
                                r_mem_addr  <= {r_page, r_idx};
                            end
                        end
                    end
                    S_ALIGN: begin
                        r_state     <= S_READ;
                        r_bus_grant <= 1'b1;
                        r_mem_rd    <= 1'b1;
                        r_mem_addr  <= {r_page, r_idx};
                    end
                    S_READ: begin
                        r_state        <= S_WRITE;
                        r_ppu_wdata    <= bus.mem_rdata;
                        r_mem_rd       <= 1'b0;
                        r_ppu_reg_cs   <= 1'b1;
                        r_ppu_reg_addr <= OAM_DATA_REG;
                        r_ppu_we       <= 1'b1;
                    end
                    S_WRITE: begin
                        r_idx          <= w_idx_inc;
                        r_ppu_reg_cs   <= 1'b0;
                        r_ppu_reg_addr <= 3'd0;
                        r_ppu_we       <= 1'b0;
                        if (r_idx == c_last_idx) begin
                            r_state     <= S_IDLE;
                            r_bus_grant <= 1'b0;
                            r_busy      <= 1'b0;
                            r_stall     <= 1'b0;
                        end else begin
                            r_state    <= S_READ;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= {r_page, w_idx_inc};
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rdy_out      = bus.rdy_in & ~r_stall;
    assign bus.bus_grant    = r_bus_grant;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_rd       = r_mem_rd;
    assign bus.ppu_reg_cs   = r_ppu_reg_cs;
    assign bus.ppu_reg_addr = r_ppu_reg_addr;
    assign bus.ppu_wdata    = r_ppu_wdata;
    assign bus.ppu_we       = r_ppu_we;
    assign bus.dma_busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma_controller
// Brief    : Randomized scoreboard bench for the sprite DMA sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_controller;

    localparam int XFER_LEN = 256;

    typedef struct packed {
        logic [2:0] reg_addr;
        logic [7:0] data;
    } wr_t;

    logic CLOCK_50;
    logic reset;
    oam_dma_controller_if bus_if ();

    oam_dma_controller #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_REG (3'd4),
        .XFER_LEN     (XFER_LEN)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus_if.master)
    );

    logic [7:0] ram [0:65535];
    assign bus_if.mem_rdata = ram[bus_if.mem_addr];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ce_count = 0;
    int         stall_cnt = 0;
    int         rd_total = 0;
    int         mon_writes = 0;
    logic [7:0] mon_page = 8'd0;
    logic [7:0] mon_rd_idx = 8'd0;
    wr_t        sb [$];

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One CPU cycle: inputs held while cpu_ce is high for a single CLOCK_50 edge.
    task automatic tick(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        input logic rdy);
        @(negedge CLOCK_50);
        bus_if.cpu_we    = we;
        bus_if.cpu_addr  = addr;
        bus_if.cpu_wdata = wd;
        bus_if.rdy_in    = rdy;
        bus_if.cpu_ce    = 1'b1;
        @(negedge CLOCK_50);
        bus_if.cpu_ce    = 1'b0;
        @(negedge CLOCK_50);
        ce_count++;
    endtask

    // Monitor: checks every read address and every qualified OAM write.
    always @(negedge CLOCK_50) begin
        wr_t e;
        #2;
        if (!reset && bus_if.cpu_ce) begin
            if (!bus_if.rdy_out) stall_cnt++;
            if (bus_if.mem_rd) begin
                chk("mem_addr", 32'(bus_if.mem_addr), 32'({mon_page, mon_rd_idx}));
                if (bus_if.rdy_in) begin
                    mon_rd_idx = mon_rd_idx + 8'd1;
                    rd_total++;
                end
            end
            if (bus_if.ppu_we && bus_if.rdy_in) begin
                mon_writes++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ppu_write: got data 0x%0h, expected no write",
                             bus_if.ppu_wdata);
                end else begin
                    e = sb.pop_front();
                    chk("ppu_wdata", 32'(bus_if.ppu_wdata), 32'(e.data));
                    chk("ppu_reg_addr", 32'(bus_if.ppu_reg_addr), 32'(e.reg_addr));
                    chk("ppu_reg_cs", 32'(bus_if.ppu_reg_cs), 32'd1);
                end
            end
        end
    end

    // parity_sel: 0/1 = trigger in an even/odd CPU cycle (counted from 1 after reset), 2 = as-is.
    task automatic xfer(input logic [7:0] page, input int parity_sel, input int h,
                        input int pause_at, input int retrig_at, input int abort_at);
        int  k, exp_stall, guard, w0;
        bit  paused, retrig;
        paused = 1'b0;
        retrig = 1'b0;
        if (parity_sel != 2 && ((ce_count + 1) % 2) != parity_sel)
            tick(1'b0, 16'h8000, 8'h00, 1'b1);
        for (int i = 0; i < XFER_LEN; i++)
            sb.push_back('{reg_addr: 3'd4, data: ram[{page, 8'(i)}]});
        mon_page   = page;
        mon_rd_idx = 8'd0;
        rd_total   = 0;
        stall_cnt  = 0;
        k          = ce_count;
        tick(1'b1, 16'h4014, page, 1'b1);
        chk("busy_on_trigger", 32'(bus_if.dma_busy), 32'd1);
        chk("rdy_out_on_trigger", 32'(bus_if.rdy_out), 32'd0);
        repeat (h) tick(1'b1, 16'h01FD, 8'h55, 1'b1);
        exp_stall = 1 + h + ((k + 1 + h) % 2) + 2 * XFER_LEN + ((pause_at >= 0) ? 10 : 0);
        guard = 0;
        while (bus_if.dma_busy && guard < 3000) begin
            guard++;
            if (abort_at >= 0 && bus_if.mem_rd && bus_if.mem_addr[7:0] == 8'(abort_at)) begin
                #1 reset = 1'b1;
                @(posedge CLOCK_50);
                #1;
                chk("abort_rdy_out", 32'(bus_if.rdy_out), 32'(bus_if.rdy_in));
                chk("abort_dma_busy", 32'(bus_if.dma_busy), 32'd0);
                chk("abort_bus_grant", 32'(bus_if.bus_grant), 32'd0);
                chk("abort_ppu_we", 32'(bus_if.ppu_we), 32'd0);
                sb.delete();
                w0 = mon_writes;
                @(negedge CLOCK_50);
                reset    = 1'b0;
                ce_count = 0;
                repeat (20) tick(1'b0, 16'h8000, 8'h00, 1'b1);
                chk("no_write_after_reset", 32'(mon_writes - w0), 32'd0);
                chk("idle_after_reset", 32'(bus_if.dma_busy), 32'd0);
                return;
            end else if (pause_at >= 0 && !paused && bus_if.mem_rd &&
                         bus_if.mem_addr[7:0] == 8'(pause_at)) begin
                paused = 1'b1;
                repeat (10) tick(1'b0, 16'h8000, 8'h00, 1'b0);
            end else if (retrig_at >= 0 && !retrig && bus_if.mem_rd &&
                         bus_if.mem_addr[7:0] == 8'(retrig_at)) begin
                retrig = 1'b1;
                tick(1'b1, 16'h4014, 8'h03, 1'b1);
            end else begin
                tick(1'b0, 16'($urandom_range(0, 32767)), 8'h00, 1'b1);
            end
        end
        chk("xfer_timeout", 32'(guard < 3000), 32'd1);
        chk("stall_len", 32'(stall_cnt), 32'(exp_stall));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("read_count", 32'(rd_total), 32'(XFER_LEN));
        chk("rdy_released", 32'(bus_if.rdy_out), 32'd1);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[{8'h02, 8'(i)}] = 8'(i) ^ 8'hA5;

        reset            = 1'b1;
        bus_if.cpu_ce    = 1'b0;
        bus_if.rdy_in    = 1'b1;
        bus_if.cpu_addr  = 16'h0000;
        bus_if.cpu_wdata = 8'h00;
        bus_if.cpu_we    = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #2;
        chk("rst_rdy_out", 32'(bus_if.rdy_out), 32'd1);
        chk("rst_bus_grant", 32'(bus_if.bus_grant), 32'd0);
        chk("rst_mem_rd", 32'(bus_if.mem_rd), 32'd0);
        chk("rst_ppu_reg_cs", 32'(bus_if.ppu_reg_cs), 32'd0);
        chk("rst_ppu_we", 32'(bus_if.ppu_we), 32'd0);
        chk("rst_dma_busy", 32'(bus_if.dma_busy), 32'd0);
        chk("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        chk("rst_ppu_wdata", 32'(bus_if.ppu_wdata), 32'd0);
        bus_if.rdy_in = 1'b0;
        #1;
        chk("rst_rdy_follows", 32'(bus_if.rdy_out), 32'd0);
        bus_if.rdy_in = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;

        tick(1'b1, 16'h4015, 8'h07, 1'b1);
        chk("wrong_addr_no_trigger", 32'(bus_if.dma_busy), 32'd0);
        tick(1'b1, 16'h4014, 8'h07, 1'b0);
        chk("paused_no_trigger", 32'(bus_if.dma_busy), 32'd0);
        tick(1'b0, 16'h4014, 8'h07, 1'b1);
        chk("read_no_trigger", 32'(bus_if.dma_busy), 32'd0);

        xfer(8'h02, 0, 0, -1, -1, -1);
        xfer(8'h02, 1, 0, -1, -1, -1);
        xfer(8'h02, 0, 2, -1, -1, -1);
        xfer(8'h02, 0, 0, 8'h80, -1, -1);
        xfer(8'h02, 2, 0, -1, 8'h10, -1);
        xfer(8'h02, 2, 0, -1, -1, 8'h40);
        for (int r = 0; r < 4; r++)
            xfer(8'($urandom), 2, int'($urandom_range(0, 3)), -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
